// File: rtl/trc_pkg.sv
// Shared TRC register map, PMA feature offsets, status bit positions and sequencer state encoding.
// Used by the reconfig sequencer and its Avalon-MM master.
package trc_pkg;

  localparam logic [6:0] PMA_CH_NR  = 7'h08;
  localparam logic [6:0] PMA_STATUS = 7'h0A;
  localparam logic [6:0] PMA_OFFSET = 7'h0B;
  localparam logic [6:0] PMA_DATA   = 7'h0C;

  localparam logic [1:0] FEAT_VOD  = 2'd0;
  localparam logic [1:0] FEAT_PRE  = 2'd1;
  localparam logic [1:0] FEAT_POST = 2'd2;

  localparam int STAT_BUSY = 8;
  localparam int STAT_ERR  = 9;

  localparam logic [31:0] GO_CMD = 32'h0000_0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_CH,
    S_OFS,
    S_DAT,
    S_GO,
    S_ERR,
    S_DONE
  } state_t;

  function automatic logic [31:0] zext6(input logic [5:0] v);
    return {26'd0, v};
  endfunction

endpackage

// File: rtl/trc_av_master.sv
// Single-transfer Avalon-MM master: latches a request while idle, holds it through waitrequest,
// and acks in the completion cycle with readdata passed through; abort drops a pending transfer.
module trc_av_master (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [6:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_abort,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic [6:0]  o_av_address,
  output logic        o_av_write,
  output logic        o_av_read,
  output logic [31:0] o_av_writedata,
  input  logic [31:0] i_av_readdata,
  input  logic        i_av_waitrequest
);

  logic        r_write;
  logic        r_read;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic        w_active;

  assign w_active = r_write | r_read;
  assign o_ack    = w_active & ~i_av_waitrequest & ~i_abort;
  assign o_rdata  = i_av_readdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_abort) begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
    end else if (w_active) begin
      if (!i_av_waitrequest) begin
        r_write <= 1'b0;
        r_read  <= 1'b0;
      end
    end else if (i_req) begin
      r_write <= i_wr;
      r_read  <= ~i_wr;
      r_addr  <= i_addr;
      r_wdata <= i_wr ? i_wdata : 32'd0;
    end
  end

  assign o_av_address   = r_addr;
  assign o_av_write     = r_write;
  assign o_av_read      = r_read;
  assign o_av_writedata = r_wdata;

endmodule

// File: rtl/trc_reconfig_sequencer.sv
// Walks enabled channels writing VOD/pre-tap/post-tap through the TRC controller, polling busy with timeout.
// Reports a done or error pulse; err_ch names the channel in flight when the error fired.
module trc_reconfig_sequencer
  import trc_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 6,
  parameter int VOD_DEF  = 10,
  parameter int PRE_DEF  = 0,
  parameter int POST_DEF = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [NUM_CH-1:0] i_ch_mask,
  input  logic              i_use_default,
  input  logic [5:0]        i_vod,
  input  logic [5:0]        i_pre,
  input  logic [5:0]        i_post,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [CH_W-1:0]   o_err_ch,
  output logic [6:0]        o_av_address,
  output logic              o_av_write,
  output logic              o_av_read,
  output logic [31:0]       o_av_writedata,
  input  logic [31:0]       i_av_readdata,
  input  logic              i_av_waitrequest
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [NUM_CH-1:0] r_rem;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_err_ch;
  logic [1:0]        r_feat;
  logic [5:0]        r_vod;
  logic [5:0]        r_pre;
  logic [5:0]        r_post;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_req;
  logic              w_wr;
  logic [6:0]        w_addr;
  logic [31:0]       w_wdata;
  logic              w_abort;
  logic              w_ack;
  logic [31:0]       w_rdata;
  logic              w_tmo;
  logic [CH_W-1:0]   w_nxt_idx;
  logic [5:0]        w_val;
  logic              w_unused_rd;

  trc_av_master u_av (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_req            (w_req),
    .i_wr             (w_wr),
    .i_addr           (w_addr),
    .i_wdata          (w_wdata),
    .i_abort          (w_abort),
    .o_ack            (w_ack),
    .o_rdata          (w_rdata),
    .o_av_address     (o_av_address),
    .o_av_write       (o_av_write),
    .o_av_read        (o_av_read),
    .o_av_writedata   (o_av_writedata),
    .i_av_readdata    (i_av_readdata),
    .i_av_waitrequest (i_av_waitrequest)
  );

  assign w_unused_rd = ^{w_rdata[31:10], w_rdata[7:0]};

  // Lowest remaining channel wins, giving an ascending scan.
  always_comb begin
    w_nxt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_rem[i]) w_nxt_idx = CH_W'(i);
    end
  end

  always_comb begin
    case (r_feat)
      FEAT_VOD: w_val = r_vod;
      FEAT_PRE: w_val = r_pre;
      default:  w_val = r_post;
    endcase
  end

  assign w_tmo = (r_state == S_POLL) && (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_req   = 1'b0;
    w_wr    = 1'b0;
    w_addr  = PMA_STATUS;
    w_wdata = '0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_nxt = S_POLL;
      S_POLL: begin
        w_req = 1'b1;
        // Timeout beats a read completing in the same cycle.
        if (w_tmo) begin
          w_abort = 1'b1;
          w_nxt   = S_ERR;
        end else if (w_ack && !w_rdata[STAT_BUSY]) begin
          if (w_rdata[STAT_ERR]) w_nxt = S_ERR;
          else if (|r_rem)       w_nxt = S_CH;
          else                   w_nxt = S_DONE;
        end
      end
      S_CH: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = PMA_CH_NR;
        w_wdata = 32'(r_ch);
        if (w_ack) w_nxt = S_OFS;
      end
      S_OFS: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = PMA_OFFSET;
        w_wdata = {30'd0, r_feat};
        if (w_ack) w_nxt = S_DAT;
      end
      S_DAT: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = PMA_DATA;
        w_wdata = zext6(w_val);
        if (w_ack) w_nxt = (r_feat == FEAT_POST) ? S_GO : S_OFS;
      end
      S_GO: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = PMA_STATUS;
        w_wdata = GO_CMD;
        if (w_ack) w_nxt = S_POLL;
      end
      S_ERR:   w_nxt = S_IDLE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem    <= '0;
      r_ch     <= '0;
      r_err_ch <= '0;
      r_feat   <= FEAT_VOD;
      r_vod    <= '0;
      r_pre    <= '0;
      r_post   <= '0;
      r_tmo    <= '0;
    end else begin
      r_tmo <= (r_state == S_POLL) ? r_tmo + TMO_W'(1) : '0;
      if (r_state == S_IDLE && i_start) begin
        r_rem    <= i_ch_mask;
        r_ch     <= '0;
        r_err_ch <= '0;
        r_feat   <= FEAT_VOD;
        r_vod    <= i_use_default ? 6'(VOD_DEF)  : i_vod;
        r_pre    <= i_use_default ? 6'(PRE_DEF)  : i_pre;
        r_post   <= i_use_default ? 6'(POST_DEF) : i_post;
      end
      if (r_state == S_POLL && w_nxt == S_CH) begin
        r_ch  <= w_nxt_idx;
        r_rem <= r_rem & ~(NUM_CH'(1) << w_nxt_idx);
      end
      if (r_state == S_CH && w_ack) r_feat <= FEAT_VOD;
      if (r_state == S_DAT && w_ack && r_feat != FEAT_POST) r_feat <= r_feat + 2'd1;
      if (r_state == S_POLL && w_nxt == S_ERR) r_err_ch <= r_ch;
    end
  end

  assign o_busy   = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign o_done   = (r_state == S_DONE);
  assign o_error  = (r_state == S_ERR);
  assign o_err_ch = r_err_ch;

endmodule

// File: tb/tb_trc_reconfig_sequencer.sv
// Directed bench for trc_reconfig_sequencer with a behavioural TRC slave that logs every completed access.
// Expected access lists are built from the register map; timeout run uses TIMEOUT=16.
module tb_trc_reconfig_sequencer;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              use_default = 1'b0;
  logic [5:0]        vod = '0, pre = '0, post = '0;
  logic              busy, done, error;
  logic [CH_W-1:0]   err_ch;
  logic [6:0]        av_address;
  logic              av_write, av_read;
  logic [31:0]       av_writedata;
  logic [31:0]       av_readdata = '0;
  logic              av_waitrequest = 1'b0;

  always #5 clk = ~clk;

  trc_reconfig_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .VOD_DEF(10), .PRE_DEF(0), .POST_DEF(0), .TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ch_mask(ch_mask),
    .i_use_default(use_default), .i_vod(vod), .i_pre(pre), .i_post(post),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_ch(err_ch),
    .o_av_address(av_address), .o_av_write(av_write), .o_av_read(av_read),
    .o_av_writedata(av_writedata), .i_av_readdata(av_readdata),
    .i_av_waitrequest(av_waitrequest)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] acc(input logic wr, input logic [6:0] a, input logic [31:0] d);
    return {24'd0, wr, a, d};
  endfunction

  // Slave model: stalls each access wait_cfg cycles, then completes it and logs it.
  int          cyc = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          st_mode = 0;
  logic        stuck = 1'b0;
  int          last_ch = 0;
  int          done_cnt = 0, err_cnt = 0, go_cyc = 0, err_cyc = 0;
  logic [63:0] log_q[$];
  logic [40:0] hold;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
      chk("busy_at_error", busy, 0);
    end
    if (av_read || av_write) begin
      if (wcnt == 0) hold = {av_write, av_read, av_address, av_writedata};
      else chk("stall_hold", {av_write, av_read, av_address, av_writedata}, hold);
      if (wcnt < wait_cfg) begin
        av_waitrequest = 1'b1;
        wcnt++;
      end else begin
        av_waitrequest = 1'b0;
        wcnt = 0;
        chk("one_strobe", av_read & av_write, 0);
        log_q.push_back(acc(av_write, av_address, av_write ? av_writedata : 32'd0));
        if (av_write && av_address == 7'h08) last_ch = int'(av_writedata);
        if (av_write && av_address == 7'h0A) begin
          go_cyc = cyc;
          if ((st_mode == 1 && last_ch == 0) || (st_mode == 2 && last_ch == 1)) stuck = 1'b1;
        end
        av_readdata = (av_read && stuck) ? ((st_mode == 1) ? 32'h100 : 32'h200) : 32'd0;
      end
    end else begin
      av_waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  task automatic clear_run();
    log_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    stuck = 1'b0;
    last_ch = 0;
  endtask

  task automatic run_seq(input logic [1:0] m, input logic ud, input logic [5:0] v, p, q,
                         input int poke);
    clear_run();
    @(negedge clk);
    start = 1'b1; ch_mask = m; use_default = ud; vod = v; pre = p; post = q;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 3000 && done_cnt == 0 && err_cnt == 0; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (i == poke) ch_mask = 2'b11;
    end
    start = 1'b0;
    chk("seq_finished", (done_cnt + err_cnt) > 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input string tag, input logic [1:0] m, input logic [5:0] v, p, q);
    logic [63:0] e[$];
    logic [5:0]  vals[3];
    vals[0] = v; vals[1] = p; vals[2] = q;
    e.push_back(acc(1'b0, 7'h0A, 32'd0));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m[ch]) begin
        e.push_back(acc(1'b1, 7'h08, 32'(ch)));
        for (int f = 0; f < 3; f++) begin
          e.push_back(acc(1'b1, 7'h0B, 32'(f)));
          e.push_back(acc(1'b1, 7'h0C, {26'd0, vals[f]}));
        end
        e.push_back(acc(1'b1, 7'h0A, 32'h1));
        e.push_back(acc(1'b0, 7'h0A, 32'd0));
      end
    end
    chk({tag, "_len"}, log_q.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < log_q.size()) chk($sformatf("%s_acc%0d", tag, i), log_q[i], e[i]);
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_ch", err_ch, 0);
    chk("rst_strobes", {av_write, av_read}, 0);
    chk("rst_addr_data", {av_address, av_writedata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both channels, default values, no stall.
    run_seq(2'b11, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    check_log("t1", 2'b11, 6'd10, 6'd0, 6'd0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Channel 1 only, runtime values.
    run_seq(2'b10, 1'b0, 6'd5, 6'd2, 6'd7, -1);
    check_log("t2", 2'b10, 6'd5, 6'd2, 6'd7);
    chk("t2_done_cnt", done_cnt, 1);

    // Three wait cycles on every access.
    wait_cfg = 3;
    run_seq(2'b11, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    check_log("t3", 2'b11, 6'd10, 6'd0, 6'd0);
    chk("t3_done_cnt", done_cnt, 1);
    wait_cfg = 0;

    // Busy stuck after channel 0 GO: 16 POLL cycles then ERR.
    st_mode = 1;
    run_seq(2'b11, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_err_ch", err_ch, 0);
    chk("t4_err_delay", err_cyc - go_cyc, 17);
    chk("t4_busy", busy, 0);
    chk("t4_strobes", {av_write, av_read}, 0);

    // Controller error bit after channel 1 GO.
    st_mode = 2;
    run_seq(2'b11, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_err_ch", err_ch, 1);
    chk("t5_last_ch", last_ch, 1);
    st_mode = 0;

    // Asynchronous reset in the middle of a DATA write.
    clear_run();
    @(negedge clk);
    start = 1'b1; ch_mask = 2'b11; use_default = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(av_write && av_address == 7'h0C); i++) @(negedge clk);
    chk("t6_dat_seen", {av_write, av_address}, {1'b1, 7'h0C});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_strobes_async", {av_write, av_read}, 0);
    chk("t6_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_seq(2'b11, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    check_log("t6", 2'b11, 6'd10, 6'd0, 6'd0);
    chk("t6_done_cnt", done_cnt, 1);

    // Start pulse while busy is ignored.
    run_seq(2'b01, 1'b1, 6'd0, 6'd0, 6'd0, 5);
    check_log("t7", 2'b01, 6'd10, 6'd0, 6'd0);
    chk("t7_done_cnt", done_cnt, 1);

    // Start coinciding with the done pulse is ignored.
    clear_run();
    @(negedge clk);
    start = 1'b1; ch_mask = 2'b11; use_default = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk("t8_done_seen", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t8_log_len", log_q.size(), 19);
    chk("t8_busy", busy, 0);
    chk("t8_done_cnt", done_cnt, 1);

    // Empty mask: one status read, then done.
    run_seq(2'b00, 1'b1, 6'd0, 6'd0, 6'd0, -1);
    check_log("t9", 2'b00, 6'd10, 6'd0, 6'd0);
    chk("t9_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
